// File: rtl/boreal_uart_mmio_bridge_if.sv
// Memory-side port of the Boreal UART bridge: weight RAM write strobe, read strobe, address and data.
interface boreal_uart_mmio_bridge_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (output mem_we, mem_re, mem_addr, mem_din, input mem_dout);
    modport slave  (input mem_we, mem_re, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/boreal_uart_mmio_bridge.sv
// UART 8N1 to weight-memory bridge: framed command parser, memory write/read, learning freeze control.
// Optional macro BOREAL_UART_ACK_EN: acknowledge WRITE/FREEZE/RESUME and report checksum errors on tx.
//
// state    | meaning
// P_IDLE   | waiting for 0xAA sync byte
// P_CMD    | expecting command byte
// P_AH     | expecting address high byte
// P_AL     | expecting address low byte
// P_DATA   | collecting DATA_BYTES data bytes, MSB first
// P_CHK    | expecting checksum byte
// P_EXEC   | applying the command; strobes launched on exit
// P_RDWAIT | mem_re high, memory responding
// P_RDCAP  | capturing mem_dout into the response buffer
// P_RESP   | transmitting the response frame
module boreal_uart_mmio_bridge #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int ADDR_W      = 10,
    parameter int DATA_BYTES  = 2,
    parameter int TIMEOUT_BIT = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx,
    output logic                             tx,
    boreal_uart_mmio_bridge_if.master        mem,
    output logic                             learn_freeze,
    output logic [7:0]                       crc_err_cnt,
    output logic                             busy
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W  = $clog2(DIV);
    localparam int TO_CYC = TIMEOUT_BIT * DIV;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    localparam logic [7:0] SYNC_REQ   = 8'hAA;
    localparam logic [7:0] SYNC_RSP   = 8'h55;
    localparam logic [7:0] ERR_CODE   = 8'hEE;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_FREEZE = 8'h02;
    localparam logic [7:0] CMD_RESUME = 8'h03;
    localparam logic [7:0] CMD_READ   = 8'h04;

`ifdef BOREAL_UART_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        P_IDLE, P_CMD, P_AH, P_AL, P_DATA, P_CHK, P_EXEC, P_RDWAIT, P_RDCAP, P_RESP
    } state_t;

    state_t state, state_nxt;

    logic             rx_s1, rx_s2, rx_s3, rx_act, rx_valid, rx_ferr;
    logic [3:0]       rx_bit;
    logic [CNT_W-1:0] rx_cnt;
    logic [7:0]       rx_sh;

    logic             tx_busy, tx_start;
    logic [3:0]       tx_bit;
    logic [CNT_W-1:0] tx_cnt;
    logic [8:0]       tx_sh;
    logic [7:0]       tx_byte;

    logic [7:0]        cmd, chk_acc, rsp_cmd, rsp_chk;
    logic [15:0]       addr_hl;
    logic [DATA_W-1:0] data, rsp_data;
    logic [1:0]        dcnt;
    logic [2:0]        rsp_idx, rsp_dend;
    logic [TO_W-1:0]   to_cnt;
    logic              in_frame, chk_bad, err_inc;

    function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] d);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < DATA_BYTES; i++) x = x ^ d[8*i +: 8];
        return x;
    endfunction

    assign busy     = (state != P_IDLE);
    assign in_frame = state inside {P_CMD, P_AH, P_AL, P_DATA, P_CHK};
    assign chk_bad  = (state == P_CHK) && rx_valid && (rx_sh != chk_acc);
    // a malformed byte in IDLE only counts if it looked like a sync attempt
    assign err_inc  = chk_bad || (rx_ferr && ((state != P_IDLE) || (rx_sh == SYNC_REQ)));

    // receiver: start re-checked at half bit, then data and stop sampled at bit centres
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_act   <= 1'b0;
            rx_bit   <= '0;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_act) begin
                if (rx_s3 && !rx_s2) begin
                    rx_act <= 1'b1;
                    rx_bit <= '0;
                    rx_cnt <= CNT_W'(DIV / 2 - 1);
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CNT_W'(1);
            end else begin
                rx_cnt <= CNT_W'(DIV - 1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_act <= 1'b0;
                end else if (rx_bit <= 4'd8) begin
                    rx_sh <= {rx_s2, rx_sh[7:1]};
                end else begin
                    rx_act <= 1'b0;
                    if (rx_s2) rx_valid <= 1'b1;
                    else       rx_ferr  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx      <= 1'b0;
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, tx_byte};
                tx_bit  <= '0;
                tx_cnt  <= CNT_W'(DIV - 1);
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_W'(1);
        end else if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
        end else begin
            tx     <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 4'd1;
            tx_cnt <= CNT_W'(DIV - 1);
        end
    end

    always_comb begin
        tx_byte = rsp_chk;
        if (rsp_idx == 3'd0)         tx_byte = SYNC_RSP;
        else if (rsp_idx == 3'd1)    tx_byte = rsp_cmd;
        else if (rsp_idx < rsp_dend) tx_byte = rsp_data[DATA_W-1 -: 8];
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            P_IDLE: if (rx_valid && rx_sh == SYNC_REQ) state_nxt = P_CMD;
            P_CMD:  if (rx_valid) state_nxt = P_AH;
            P_AH:   if (rx_valid) state_nxt = P_AL;
            P_AL:   if (rx_valid) state_nxt = P_DATA;
            P_DATA: if (rx_valid && dcnt == 2'd0) state_nxt = P_CHK;
            P_CHK: begin
                if (rx_valid) begin
                    if (rx_sh == chk_acc) state_nxt = P_EXEC;
                    else                  state_nxt = ACK_EN ? P_RESP : P_IDLE;
                end
            end
            P_EXEC: begin
                if (cmd == CMD_READ)
                    state_nxt = P_RDWAIT;
                else if (ACK_EN && (cmd == CMD_WRITE || cmd == CMD_FREEZE || cmd == CMD_RESUME))
                    state_nxt = P_RESP;
                else
                    state_nxt = P_IDLE;
            end
            P_RDWAIT: state_nxt = P_RDCAP;
            P_RDCAP:  state_nxt = P_RESP;
            P_RESP: begin
                if (!tx_busy) begin
                    if (rsp_idx > rsp_dend) state_nxt = P_IDLE;
                    else                    tx_start  = 1'b1;
                end
            end
            default: state_nxt = P_IDLE;
        endcase
        if (in_frame && (rx_ferr || to_cnt == '0)) state_nxt = P_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= P_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd          <= '0;
            chk_acc      <= '0;
            addr_hl      <= '0;
            data         <= '0;
            dcnt         <= '0;
            rsp_cmd      <= '0;
            rsp_chk      <= '0;
            rsp_data     <= '0;
            rsp_idx      <= '0;
            rsp_dend     <= '0;
            to_cnt       <= TO_W'(TO_CYC);
            mem.mem_we   <= 1'b0;
            mem.mem_re   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            learn_freeze <= 1'b0;
            crc_err_cnt  <= '0;
        end else begin
            mem.mem_we <= 1'b0;
            mem.mem_re <= 1'b0;
            if (state == P_IDLE || rx_valid) to_cnt <= TO_W'(TO_CYC);
            else if (to_cnt != '0)           to_cnt <= to_cnt - TO_W'(1);
            if (err_inc && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
            if (rx_valid && state inside {P_CMD, P_AH, P_AL, P_DATA}) chk_acc <= chk_acc ^ rx_sh;
            case (state)
                P_IDLE: chk_acc <= '0;
                P_CMD:  if (rx_valid) cmd <= rx_sh;
                P_AH:   if (rx_valid) addr_hl[15:8] <= rx_sh;
                P_AL: begin
                    if (rx_valid) begin
                        addr_hl[7:0] <= rx_sh;
                        dcnt         <= 2'(DATA_BYTES - 1);
                    end
                end
                P_DATA: begin
                    if (rx_valid) begin
                        data <= DATA_W'({data, rx_sh});
                        dcnt <= dcnt - 2'd1;
                    end
                end
                P_CHK: begin
                    if (chk_bad) begin
                        rsp_cmd  <= ERR_CODE;
                        rsp_chk  <= ERR_CODE;
                        rsp_dend <= 3'd2;
                        rsp_idx  <= '0;
                    end
                end
                P_EXEC: begin
                    rsp_cmd  <= cmd;
                    rsp_chk  <= cmd;
                    rsp_dend <= 3'd2;
                    rsp_idx  <= '0;
                    case (cmd)
                        CMD_WRITE: begin
                            mem.mem_we   <= 1'b1;
                            mem.mem_addr <= addr_hl[ADDR_W-1:0];
                            mem.mem_din  <= data;
                        end
                        CMD_FREEZE: learn_freeze <= 1'b1;
                        CMD_RESUME: learn_freeze <= 1'b0;
                        CMD_READ: begin
                            mem.mem_re   <= 1'b1;
                            mem.mem_addr <= addr_hl[ADDR_W-1:0];
                        end
                        default: ;
                    endcase
                end
                P_RDCAP: begin
                    rsp_data <= mem.mem_dout;
                    rsp_chk  <= cmd ^ xor_bytes(mem.mem_dout);
                    rsp_dend <= 3'(2 + DATA_BYTES);
                end
                P_RESP: begin
                    if (tx_start) begin
                        rsp_idx <= rsp_idx + 3'd1;
                        if (rsp_idx >= 3'd2 && rsp_idx < rsp_dend) rsp_data <= rsp_data << 8;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boreal_uart_mmio_bridge.sv
// Directed bench for boreal_uart_mmio_bridge at DIV=16; honours BOREAL_UART_ACK_EN when defined.
module tb_boreal_uart_mmio_bridge;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tx;
    logic       learn_freeze;
    logic [7:0] crc_err_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0, re_cnt = 0;
    logic [9:0]  we_addr = '0, re_addr = '0;
    logic [15:0] we_din = '0;
    logic [7:0]  txq[$];

    boreal_uart_mmio_bridge_if #(.ADDR_W(10), .DATA_W(16)) mem_if ();

    boreal_uart_mmio_bridge #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .ADDR_W(10), .DATA_BYTES(2), .TIMEOUT_BIT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .mem(mem_if),
        .learn_freeze(learn_freeze), .crc_err_cnt(crc_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_if.mem_we) begin
            we_cnt++;
            we_addr = mem_if.mem_addr;
            we_din  = mem_if.mem_din;
        end
        if (mem_if.mem_re) begin
            re_cnt++;
            re_addr = mem_if.mem_addr;
        end
    end

    // line decoder for tx, sampling at bit centres
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                logic [7:0] b;
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                check("tx_stop_bit", 32'(tx), 1);
                txq.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [55:0] f);
        for (int i = 6; i >= 0; i--) send_byte(f[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(n < 3000), 1);
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_ack(input string tag, input logic [7:0] c, input logic [7:0] k);
`ifdef BOREAL_UART_ACK_EN
        check({tag, "_ack_len"}, 32'(txq.size()), 3);
        check({tag, "_ack_b0"}, 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'h55);
        check({tag, "_ack_b1"}, 32'(txq.size() > 1 ? txq[1] : 8'h00), 32'(c));
        check({tag, "_ack_b2"}, 32'(txq.size() > 2 ? txq[2] : 8'h00), 32'(k));
`else
        check({tag, "_tx_silent"}, 32'(txq.size()), 0);
`endif
        txq.delete();
    endtask

    initial begin
        logic [7:0] exp_rd [5];
        int we0, re0;
        exp_rd = '{8'h55, 8'h04, 8'h12, 8'h34, 8'h22};
        rx = 1'b1;
        rst_n = 1'b0;
        mem_if.mem_dout = 16'h1234;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_we", 32'(mem_if.mem_we), 0);
        check("rst_re", 32'(mem_if.mem_re), 0);
        check("rst_addr", 32'(mem_if.mem_addr), 0);
        check("rst_din", 32'(mem_if.mem_din), 0);
        check("rst_freeze", 32'(learn_freeze), 0);
        check("rst_crc", 32'(crc_err_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // write, checksum 0x7F = 01^03^2C^BE^EF
        we0 = we_cnt;
        send_frame(56'hAA_01_03_2C_BE_EF_7F);
        wait_idle("wr");
        check("wr_we_cycles", we_cnt - we0, 1);
        check("wr_addr", 32'(we_addr), 32'h32C);
        check("wr_din", 32'(we_din), 32'hBEEF);
        expect_ack("wr", 8'h01, 8'h01);

        // read of 0x010, memory returns 0x1234
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte(8'hAA, 1'b1);
        check("rd_busy_after_sync", 32'(busy), 1);
        for (int i = 5; i >= 0; i--) send_byte(8'(48'h04_00_10_00_00_14 >> (8*i)), 1'b1);
        wait_idle("rd");
        check("rd_re_cycles", re_cnt - re0, 1);
        check("rd_addr", 32'(re_addr), 32'h010);
        check("rd_no_write", we_cnt - we0, 0);
        check("rd_resp_len", 32'(txq.size()), 5);
        for (int i = 0; i < 5; i++)
            check("rd_resp_byte", 32'(i < txq.size() ? txq[i] : 8'h00), 32'(exp_rd[i]));
        txq.delete();

        // bad checksum
        we0 = we_cnt;
        send_frame(56'hAA_01_00_01_00_05_00);
        wait_idle("bad");
        check("bad_no_write", we_cnt - we0, 0);
        check("bad_crc_cnt", 32'(crc_err_cnt), 1);
        expect_ack("bad", 8'hEE, 8'hEE);

        // freeze / resume
        send_frame(56'hAA_02_00_00_00_00_02);
        wait_idle("frz");
        check("frz_freeze", 32'(learn_freeze), 1);
        expect_ack("frz", 8'h02, 8'h02);
        send_frame(56'hAA_03_00_00_00_00_03);
        wait_idle("res");
        check("res_freeze", 32'(learn_freeze), 0);
        expect_ack("res", 8'h03, 8'h03);

        // inter-byte timeout abandons the partial frame
        we0 = we_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h03, 1'b1);
        check("to_busy_mid_frame", 32'(busy), 1);
        repeat (400) @(negedge clk);
        check("to_busy_expired", 32'(busy), 0);
        send_frame(56'hAA_01_00_05_12_34_22);
        wait_idle("to");
        check("to_we_cycles", we_cnt - we0, 1);
        check("to_addr", 32'(we_addr), 32'h005);
        check("to_din", 32'(we_din), 32'h1234);
        check("to_crc_unchanged", 32'(crc_err_cnt), 1);
        expect_ack("to", 8'h01, 8'h01);

        // framing errors: non-sync byte in IDLE is not counted, mid-frame one is
        send_byte(8'h12, 1'b0);
        repeat (20) @(negedge clk);
        check("fe_idle_not_counted", 32'(crc_err_cnt), 1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b0);
        repeat (20) @(negedge clk);
        check("fe_mid_counted", 32'(crc_err_cnt), 2);
        check("fe_parser_idle", 32'(busy), 0);
        send_frame(56'hAA_02_00_00_00_00_02);
        wait_idle("fe");
        check("fe_rearmed_freeze", 32'(learn_freeze), 1);
        expect_ack("fe", 8'h02, 8'h02);

        // reset after ADDR_L
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h2C, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_tx", 32'(tx), 1);
        check("mr_addr", 32'(mem_if.mem_addr), 0);
        check("mr_din", 32'(mem_if.mem_din), 0);
        check("mr_freeze", 32'(learn_freeze), 0);
        check("mr_crc", 32'(crc_err_cnt), 0);
        check("mr_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        txq.delete();
        we0 = we_cnt;
        send_frame(56'hAA_01_03_2C_BE_EF_7F);
        wait_idle("mr");
        check("mr_we_cycles", we_cnt - we0, 1);
        check("mr_wr_addr", 32'(we_addr), 32'h32C);
        check("mr_wr_din", 32'(we_din), 32'hBEEF);
        expect_ack("mr", 8'h01, 8'h01);

        // saturation: 254 sync framing errors, then two checksum errors
        for (int i = 0; i < 254; i++) send_byte(8'hAA, 1'b0);
        repeat (20) @(negedge clk);
        check("sat_crc_254", 32'(crc_err_cnt), 254);
        send_frame(56'hAA_01_00_01_00_05_00);
        wait_idle("sat1");
        check("sat_crc_255", 32'(crc_err_cnt), 255);
        send_frame(56'hAA_01_00_01_00_05_00);
        wait_idle("sat2");
        check("sat_crc_hold", 32'(crc_err_cnt), 255);
        txq.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
